// File: rtl/cache_types.sv
// Shared coherence types: request message, arbiter state encoding and the
// round-robin pick helper used by the request/response bus arbiters.
package cache_types;

   localparam int MAX_CACHES  = 8;
   localparam int MAX_ID_BITS = 3;
   localparam int ADDR_BITS   = 32;

   typedef struct packed {
      logic                 valid;
      logic [1:0]           cmd;
      logic [ADDR_BITS-1:0] addr;
   } req_msg_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_BCAST
   } arb_state_e;

   typedef struct packed {
      logic                   found;
      logic [MAX_ID_BITS-1:0] idx;
      logic [MAX_CACHES-1:0]  onehot;
   } rr_pick_t;

   // Rotate so ptr lands at bit 0, take the lowest set bit, then map back.
   // Only the low n bits take part, so the wrap works for any n in 2..8.
   function automatic rr_pick_t rr_pick(input logic [MAX_CACHES-1:0]  req,
                                        input logic [MAX_ID_BITS-1:0] ptr,
                                        input int                     n);
      rr_pick_t              r;
      logic [MAX_CACHES-1:0] rot;
      int                    j;
      int                    ofs;
      r   = '0;
      rot = '0;
      ofs = 0;
      for (int i = 0; i < MAX_CACHES; i++) begin
         j = int'(ptr) + i;
         if (j >= n) j = j - n;
         if (i < n) rot[i] = req[j];
      end
      for (int i = MAX_CACHES - 1; i >= 0; i--) begin
         if (rot[i]) begin
            r.found = 1'b1;
            ofs     = i;
         end
      end
      if (r.found) begin
         j = int'(ptr) + ofs;
         if (j >= n) j = j - n;
         r.idx       = MAX_ID_BITS'(j);
         r.onehot[j] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/coh_req_bus_arbiter_if.sv
// Coherence request bus between the dcaches and the shared arbiter.
interface coh_req_bus_arbiter_if
   import cache_types::*;
#(
   parameter int NUM_CACHES = 4,
   parameter int ID_BITS    = $clog2(NUM_CACHES)
) ();

   logic     [NUM_CACHES-1:0] req_bus_req;
   req_msg_t [NUM_CACHES-1:0] req_bus_tx;
   logic     [NUM_CACHES-1:0] req_bus_busy;
   logic     [NUM_CACHES-1:0] req_bus_gnt;
   req_msg_t                  req_bus_msg;
   logic     [ID_BITS-1:0]    bus_owner;
   logic                      hold_error;

   modport master (
      input  req_bus_req, req_bus_tx, req_bus_busy,
      output req_bus_gnt, req_bus_msg, bus_owner, hold_error
   );

   modport slave (
      output req_bus_req, req_bus_tx, req_bus_busy,
      input  req_bus_gnt, req_bus_msg, bus_owner, hold_error
   );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at WIDTH-1.
module rr_priority_picker
   import cache_types::*;
#(
   parameter int WIDTH    = 4,
   parameter int IDX_BITS = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]    req_i,
   input  logic [IDX_BITS-1:0] ptr_i,
   output logic [WIDTH-1:0]    gnt_o,
   output logic [IDX_BITS-1:0] idx_o,
   output logic                vld_o
);

   rr_pick_t pick;
   logic     unused_pick_bits;

   always_comb begin
      pick = rr_pick(MAX_CACHES'(req_i), MAX_ID_BITS'(ptr_i), WIDTH);
   end

   assign gnt_o            = pick.onehot[WIDTH-1:0];
   assign idx_o            = pick.idx[IDX_BITS-1:0];
   assign vld_o            = pick.found;
   assign unused_pick_bits = ^{pick.onehot, pick.idx};

endmodule

// File: rtl/coh_req_bus_arbiter.sv
// Round-robin owner of the coherence request bus; latches the winner's
// message and broadcasts it until no cache reports busy.
//
//   state     | meaning
//   ARB_IDLE  | bus free, pick a requester from rr_ptr upward
//   ARB_GRANT | one-cycle grant pulse, capture tx or abort if req dropped
//   ARB_BCAST | message valid, held while any cache is busy
module coh_req_bus_arbiter
   import cache_types::*;
#(
   parameter int NUM_CACHES = 4,
   parameter int ID_BITS    = $clog2(NUM_CACHES),
   parameter int MAX_HOLD   = 64,
   parameter int HOLD_BITS  = $clog2(MAX_HOLD + 1)
) (
   input logic                   clk,
   input logic                   rst,
   coh_req_bus_arbiter_if.master bus
);

   arb_state_e              state_q;
   logic [ID_BITS-1:0]      rr_ptr_q;
   logic [ID_BITS-1:0]      rr_ptr_d;
   logic [ID_BITS-1:0]      owner_q;
   logic [NUM_CACHES-1:0]   gnt_q;
   req_msg_t                msg_q;
   logic [HOLD_BITS-1:0]    hold_cnt_q;
   logic [HOLD_BITS-1:0]    hold_cnt_d;
   logic                    hold_err_q;

   logic [NUM_CACHES-1:0]   pick_gnt;
   logic [ID_BITS-1:0]      pick_idx;
   logic                    pick_vld;

   rr_priority_picker #(
      .WIDTH    (NUM_CACHES),
      .IDX_BITS (ID_BITS)
   ) u_picker (
      .req_i (bus.req_bus_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   assign hold_cnt_d = (hold_cnt_q == HOLD_BITS'(MAX_HOLD)) ? hold_cnt_q
                                                            : hold_cnt_q + HOLD_BITS'(1);
   // Explicit wrap keeps the pointer below NUM_CACHES when it is not a power of two.
   assign rr_ptr_d   = (owner_q == ID_BITS'(NUM_CACHES - 1)) ? '0
                                                             : owner_q + ID_BITS'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         gnt_q      <= '0;
         msg_q      <= '0;
         hold_cnt_q <= '0;
         hold_err_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_vld) begin
                  owner_q <= pick_idx;
                  gnt_q   <= pick_gnt;
                  state_q <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               gnt_q <= '0;
               if (bus.req_bus_req[owner_q]) begin
                  msg_q       <= bus.req_bus_tx[owner_q];
                  msg_q.valid <= 1'b1;
                  hold_cnt_q  <= '0;
                  state_q     <= ARB_BCAST;
               end else begin
                  state_q <= ARB_IDLE;
               end
            end
            ARB_BCAST: begin
               if (|bus.req_bus_busy) begin
                  hold_cnt_q <= hold_cnt_d;
                  if (hold_cnt_d == HOLD_BITS'(MAX_HOLD)) hold_err_q <= 1'b1;
               end else begin
                  msg_q.valid <= 1'b0;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= ARB_IDLE;
               end
            end
            default: begin
               gnt_q       <= '0;
               msg_q.valid <= 1'b0;
               state_q     <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.req_bus_gnt = gnt_q;
   assign bus.req_bus_msg = msg_q;
   assign bus.bus_owner   = owner_q;
   assign bus.hold_error  = hold_err_q;

endmodule

// File: tb/tb_coh_req_bus_arbiter.sv
// Directed and randomized transactions against a round-robin transaction model.
module tb_coh_req_bus_arbiter;
   import cache_types::*;

   localparam int N        = 4;
   localparam int MAX_HOLD = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   req_msg_t [N-1:0] txv;
   logic     [N-1:0] pending;
   int               m_ptr;
   logic             m_herr;

   coh_req_bus_arbiter_if #(.NUM_CACHES(N)) bus ();

   coh_req_bus_arbiter #(
      .NUM_CACHES (N),
      .MAX_HOLD   (MAX_HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: first pending cache at or after ptr, wrapping modulo N.
   function automatic int model_pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic req_msg_t rand_msg();
      req_msg_t m;
      m.valid = 1'($urandom);
      m.cmd   = 2'($urandom);
      m.addr  = $urandom;
      return m;
   endfunction

   function automatic logic [N-1:0] rand_nonzero();
      return N'($urandom_range(1, (1 << N) - 1));
   endfunction

   // One complete transaction starting with the bus idle; h = busy cycles in broadcast.
   task automatic do_txn(input logic [N-1:0] new_req, input int h, input logic [N-1:0] hbusy);
      int       w;
      req_msg_t exp_msg;
      for (int i = 0; i < N; i++) begin
         if (new_req[i] && !pending[i]) begin
            txv[i]     = rand_msg();
            pending[i] = 1'b1;
         end
      end
      if (pending == '0) begin
         txv[0]     = rand_msg();
         pending[0] = 1'b1;
      end
      bus.req_bus_tx   = txv;
      bus.req_bus_req  = pending;
      bus.req_bus_busy = N'($urandom);
      w = model_pick(pending, m_ptr);
      tick();
      chk("gnt_onehot", 64'(bus.req_bus_gnt), 64'(1) << w);
      chk("owner_at_gnt", 64'(bus.bus_owner), 64'(w));
      chk("valid_at_gnt", 64'(bus.req_bus_msg.valid), 64'(0));
      bus.req_bus_busy = N'($urandom);
      tick();
      exp_msg       = txv[w];
      exp_msg.valid = 1'b1;
      chk("bcast_msg", 64'(bus.req_bus_msg), 64'(exp_msg));
      chk("gnt_cleared", 64'(bus.req_bus_gnt), 64'(0));
      chk("owner_bcast", 64'(bus.bus_owner), 64'(w));
      pending[w]      = 1'b0;
      bus.req_bus_req = pending;
      for (int k = 1; k <= h; k++) begin
         bus.req_bus_busy = (hbusy != '0) ? hbusy : rand_nonzero();
         tick();
         chk("msg_held", 64'(bus.req_bus_msg), 64'(exp_msg));
         if (k >= MAX_HOLD) m_herr = 1'b1;
         chk("hold_error_hold", 64'(bus.hold_error), 64'(m_herr));
      end
      bus.req_bus_busy = '0;
      tick();
      chk("valid_drop", 64'(bus.req_bus_msg.valid), 64'(0));
      chk("hold_error_end", 64'(bus.hold_error), 64'(m_herr));
      m_ptr = (w + 1) % N;
   endtask

   initial begin
      int exp_idx;
      pending          = '0;
      txv              = '0;
      m_ptr            = 0;
      m_herr           = 1'b0;
      bus.req_bus_req  = '0;
      bus.req_bus_tx   = '0;
      bus.req_bus_busy = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(bus.req_bus_gnt), 64'(0));
      chk("rst_msg", 64'(bus.req_bus_msg), 64'(0));
      chk("rst_owner", 64'(bus.bus_owner), 64'(0));
      chk("rst_hold_error", 64'(bus.hold_error), 64'(0));

      // All caches requesting continuously: 3-cycle transactions, order 0,1,2,3,0.
      rst = 1'b0;
      for (int i = 0; i < N; i++) txv[i] = rand_msg();
      bus.req_bus_tx  = txv;
      bus.req_bus_req = '1;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         tick();
         if (cyc % 3 == 1) chk("fair_gnt", 64'(bus.req_bus_gnt), 64'(1) << (((cyc - 1) / 3) % N));
         else              chk("fair_gnt_idle", 64'(bus.req_bus_gnt), 64'(0));
         if (cyc % 3 == 2) begin
            exp_idx = ((cyc - 2) / 3) % N;
            chk("fair_valid", 64'(bus.req_bus_msg.valid), 64'(1));
            chk("fair_addr", 64'(bus.req_bus_msg.addr), 64'(txv[exp_idx].addr));
         end else begin
            chk("fair_valid_low", 64'(bus.req_bus_msg.valid), 64'(0));
         end
      end
      bus.req_bus_req = '0;
      m_ptr = 1;

      // Single requester 2, then pointer at 3 favours cache 3 over cache 0.
      do_txn(4'b0100, 0, '0);
      chk("single_addr_ptr", 64'(m_ptr), 64'(3));
      do_txn(4'b1001, 0, '0);
      do_txn('0, 0, '0);

      for (int t = 0; t < 40; t++) begin
         do_txn(N'($urandom) & ~pending, $urandom_range(0, 4), '0);
      end
      for (int t = 0; t < N && pending != '0; t++) do_txn('0, 0, '0);
      do_txn(4'b0001, 0, '0);

      // Abort: cache 1 drops req during its grant; pointer must stay where it was.
      bus.req_bus_req  = 4'b0010;
      bus.req_bus_busy = N'($urandom);
      tick();
      chk("abort_gnt", 64'(bus.req_bus_gnt), 64'(4'b0010));
      bus.req_bus_req = '0;
      tick();
      chk("abort_no_valid", 64'(bus.req_bus_msg.valid), 64'(0));
      chk("abort_gnt_clear", 64'(bus.req_bus_gnt), 64'(0));
      tick();
      chk("abort_idle", 64'(bus.req_bus_gnt), 64'(0));
      do_txn(4'b0110, 0, '0);
      do_txn('0, 0, '0);

      // Stall, watchdog one short of the limit, then at the limit.
      do_txn(4'b0001, 5, 4'b0010);
      do_txn(4'b0010, MAX_HOLD - 1, 4'b0010);
      chk("wd_below_limit", 64'(bus.hold_error), 64'(0));
      do_txn(4'b1000, MAX_HOLD, 4'b0001);
      chk("wd_set", 64'(bus.hold_error), 64'(1));
      do_txn(4'b0100, 0, '0);
      do_txn(4'b0011, 2, '0);
      do_txn('0, 0, '0);
      chk("wd_sticky", 64'(bus.hold_error), 64'(1));

      // Async reset mid-broadcast, away from the clock edge.
      bus.req_bus_req = 4'b1000;
      txv[3]          = rand_msg();
      bus.req_bus_tx  = txv;
      tick();
      chk("rstb_gnt", 64'(bus.req_bus_gnt), 64'(4'b1000));
      tick();
      chk("rstb_valid", 64'(bus.req_bus_msg.valid), 64'(1));
      bus.req_bus_req  = '0;
      bus.req_bus_busy = '1;
      tick();
      chk("rstb_held", 64'(bus.req_bus_msg.valid), 64'(1));
      #3;
      rst = 1'b1;
      #1;
      chk("rstb_valid_drop", 64'(bus.req_bus_msg.valid), 64'(0));
      chk("rstb_gnt_low", 64'(bus.req_bus_gnt), 64'(0));
      chk("rstb_owner", 64'(bus.bus_owner), 64'(0));
      chk("rstb_hold_error", 64'(bus.hold_error), 64'(0));
      @(posedge clk);
      #1;
      rst              = 1'b0;
      bus.req_bus_busy = '0;
      bus.req_bus_req  = 4'b0100;
      tick();
      chk("rstg_gnt", 64'(bus.req_bus_gnt), 64'(4'b0100));
      #3;
      rst = 1'b1;
      #1;
      chk("rstg_gnt_drop", 64'(bus.req_bus_gnt), 64'(0));
      chk("rstg_owner", 64'(bus.bus_owner), 64'(0));
      @(posedge clk);
      #1;
      rst             = 1'b0;
      bus.req_bus_req = '0;
      pending         = '0;
      m_ptr           = 0;
      m_herr          = 1'b0;
      do_txn(4'b1001, 0, '0);
      chk("post_rst_first", 64'(m_ptr), 64'(1));
      do_txn('0, 0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
